// File: rtl/dds_freq_meter.sv
`timescale 1ns/1ps
// DDS output monitor: measures the sample-stream period from hysteretic rising
// mid-scale crossings and recovers the tuning word with a restoring divider.
module dds_freq_meter #(
   parameter int DATA_WIDTH   = 8,
   parameter int ADDR_WIDTH   = 8,
   parameter int PERIOD_WIDTH = 12,
   parameter int WORD_WIDTH   = 3,
   parameter int HYST         = 16,
   parameter int MIN_PERIOD   = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    enable,
   input  logic [DATA_WIDTH-1:0]   data_in,
   output logic [PERIOD_WIDTH-1:0] period,
   output logic                    period_valid,
   output logic [WORD_WIDTH-1:0]   word_est,
   output logic                    word_valid,
   output logic                    no_signal,
   output logic                    busy
);

   localparam int QW = PERIOD_WIDTH + 1;
   localparam int IW = $clog2(PERIOD_WIDTH + 2);

   localparam logic [DATA_WIDTH-1:0]   MID       = {1'b1, {(DATA_WIDTH-1){1'b0}}};
   localparam logic [DATA_WIDTH-1:0]   ARM_TH    = MID - DATA_WIDTH'(HYST);
   localparam logic [PERIOD_WIDTH-1:0] CNT_ZERO  = {PERIOD_WIDTH{1'b0}};
   localparam logic [PERIOD_WIDTH-1:0] CNT_ONE   = {{(PERIOD_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [PERIOD_WIDTH-1:0] CNT_MAX   = {PERIOD_WIDTH{1'b1}};
   localparam logic [PERIOD_WIDTH-1:0] CNT_MIN   = PERIOD_WIDTH'(MIN_PERIOD);
   localparam logic [QW-1:0]           CYCLE     = QW'(2 ** ADDR_WIDTH);
   localparam logic [IW-1:0]           ITER_ZERO = {IW{1'b0}};
   localparam logic [IW-1:0]           ITER_ONE  = {{(IW-1){1'b0}}, 1'b1};
   localparam logic [IW-1:0]           ITER_LAST = IW'(PERIOD_WIDTH + 1);
   localparam logic [WORD_WIDTH-1:0]   WORD_MAX  = {WORD_WIDTH{1'b1}};
   localparam logic [WORD_WIDTH-1:0]   WORD_ZERO = {WORD_WIDTH{1'b0}};

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_SEEK    = 2'd1,
      S_MEASURE = 2'd2
   } state_t;

   state_t                  r_state;
   logic [DATA_WIDTH-1:0]   r_cur;
   logic [DATA_WIDTH-1:0]   r_prev;
   logic                    r_armed;
   logic [PERIOD_WIDTH-1:0] r_cnt;
   logic [PERIOD_WIDTH-1:0] r_div;
   logic [PERIOD_WIDTH-1:0] r_rem;
   logic [QW-1:0]           r_quo;
   logic [IW-1:0]           r_iter;

   logic                    w_cross;
   logic [QW-1:0]           w_trial;
   logic [QW-1:0]           w_sub;
   logic                    w_ge;
   logic [QW-1:0]           w_dividend;
   logic [WORD_WIDTH-1:0]   w_word_sat;

   // Crossing detect, one restoring-divider step and quotient saturation.
   always_comb begin
      w_cross    = r_armed && (r_prev < MID) && (r_cur >= MID);
      w_trial    = {r_rem, r_quo[QW-1]};
      // trial < 2*divisor always, so the sign of the difference is the compare result
      w_sub      = w_trial - {1'b0, r_div};
      w_ge       = ~w_sub[QW-1];
      w_dividend = CYCLE + {2'b00, r_cnt[PERIOD_WIDTH-1:1]};
      if (r_quo > {{(QW-WORD_WIDTH){1'b0}}, WORD_MAX}) begin
         w_word_sat = WORD_MAX;
      end else begin
         w_word_sat = r_quo[WORD_WIDTH-1:0];
      end
   end

   // Sample pipeline and hysteresis arming.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cur   <= {DATA_WIDTH{1'b0}};
         r_prev  <= {DATA_WIDTH{1'b0}};
         r_armed <= 1'b0;
      end else begin
         r_prev <= r_cur;
         r_cur  <= data_in;
         if (w_cross) begin
            r_armed <= 1'b0;
         end else if (r_cur < ARM_TH) begin
            r_armed <= 1'b1;
         end else begin
            r_armed <= r_armed;
         end
      end
   end

   // Measurement FSM, registered outputs and sequential divider.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_cnt        <= CNT_ZERO;
         r_div        <= CNT_ZERO;
         r_rem        <= CNT_ZERO;
         r_quo        <= {QW{1'b0}};
         r_iter       <= ITER_ZERO;
         period       <= CNT_ZERO;
         period_valid <= 1'b0;
         word_est     <= WORD_ZERO;
         word_valid   <= 1'b0;
         no_signal    <= 1'b0;
         busy         <= 1'b0;
      end else if (!enable) begin
         r_state      <= S_IDLE;
         r_cnt        <= CNT_ZERO;
         r_iter       <= ITER_ZERO;
         period_valid <= 1'b0;
         word_valid   <= 1'b0;
         busy         <= 1'b0;
      end else begin
         period_valid <= 1'b0;
         word_valid   <= 1'b0;
         if (busy) begin
            if (r_iter == ITER_LAST) begin
               busy       <= 1'b0;
               word_est   <= w_word_sat;
               word_valid <= 1'b1;
            end else begin
               r_rem  <= w_ge ? w_sub[PERIOD_WIDTH-1:0] : w_trial[PERIOD_WIDTH-1:0];
               r_quo  <= {r_quo[QW-2:0], w_ge};
               r_iter <= r_iter + ITER_ONE;
            end
         end
         case (r_state)
            S_IDLE: begin
               r_state <= S_SEEK;
               r_cnt   <= CNT_ZERO;
            end
            S_SEEK: begin
               if (w_cross) begin
                  r_cnt   <= CNT_ONE;
                  r_state <= S_MEASURE;
               end else if (r_cnt == CNT_MAX) begin
                  no_signal <= 1'b1;
                  word_est  <= WORD_ZERO;
                  r_cnt     <= CNT_ZERO;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            S_MEASURE: begin
               if (w_cross && (r_cnt >= CNT_MIN)) begin
                  period       <= r_cnt;
                  period_valid <= 1'b1;
                  r_cnt        <= CNT_ONE;
                  no_signal    <= 1'b0;
                  // a division already in flight finishes with its old period
                  if (!busy) begin
                     busy   <= 1'b1;
                     r_div  <= r_cnt;
                     r_rem  <= CNT_ZERO;
                     r_quo  <= w_dividend;
                     r_iter <= ITER_ZERO;
                  end
               end else if (r_cnt == CNT_MAX) begin
                  no_signal <= 1'b1;
                  word_est  <= WORD_ZERO;
                  r_cnt     <= CNT_ZERO;
                  r_state   <= S_SEEK;
               end else begin
                  r_cnt <= r_cnt + CNT_ONE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= CNT_ZERO;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dds_freq_meter.sv
`timescale 1ns/1ps
// Directed bench for dds_freq_meter: a sine-table phase-accumulator DDS drives
// the meter through word, glitch, disable, reset and stall scenarios.
module tb_dds_freq_meter;

   logic        clk;
   logic        reset;
   logic        enable;
   logic [7:0]  data_in;
   logic [11:0] period;
   logic        period_valid;
   logic [2:0]  word_est;
   logic        word_valid;
   logic        no_signal;
   logic        busy;

   logic [7:0]  sine_tbl [256];
   logic [7:0]  phase;
   logic [7:0]  step;
   logic        stall;
   logic        inject;
   int          n_checks;
   int          n_fail;

   dds_freq_meter dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .data_in      (data_in),
      .period       (period),
      .period_valid (period_valid),
      .word_est     (word_est),
      .word_valid   (word_valid),
      .no_signal    (no_signal),
      .busy         (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // DDS model: new sample every falling edge, optional glitch or stall
   initial begin
      for (int i = 0; i < 256; i++) begin
         sine_tbl[i] = 8'($rtoi(128.0 + 127.0 * $sin(6.283185307179586 * i / 256.0) + 0.5));
      end
      phase   = 8'd191;
      data_in = 8'h00;
      forever begin
         @(negedge clk);
         if (stall) begin
            data_in = 8'h80;
         end else begin
            phase = phase + step;
            if (inject && phase >= 8'd2 && phase <= 8'd4) data_in = 8'h60;
            else if (inject && phase == 8'd5) data_in = 8'h90;
            else data_in = sine_tbl[phase];
         end
      end
   end

   task automatic check_eq(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_pv(input string tag, input int budget, output int clocks);
      clocks = 0;
      do begin
         @(negedge clk);
         clocks++;
      end while (!period_valid && clocks < budget);
      check_eq(tag, int'(period_valid), 1);
   endtask

   task automatic wait_wv(input string tag, output int clocks);
      clocks = 0;
      do begin
         @(negedge clk);
         clocks++;
      end while (!word_valid && clocks < 40);
      check_eq(tag, clocks, 14);
   endtask

   // exp_period of 0 accepts the 36/37 alternation of word 7
   task automatic measure(input string tag, input int exp_period, input int exp_word);
      int n;
      wait_pv({tag, "_pv"}, 1200, n);
      if (exp_period == 0) check_eq({tag, "_period"}, int'(period == 12'd36 || period == 12'd37), 1);
      else check_eq({tag, "_period"}, int'(period), exp_period);
      wait_wv({tag, "_lat"}, n);
      check_eq({tag, "_word"}, int'(word_est), exp_word);
   endtask

   initial begin
      int n;
      int pulses;
      int steps [3];
      int periods [3];
      int words [3];
      steps   = '{2, 4, 7};
      periods = '{128, 64, 0};
      words   = '{2, 4, 7};
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b0;
      enable   = 1'b0;
      step     = 8'd1;
      stall    = 1'b0;
      inject   = 1'b0;

      repeat (3) @(negedge clk);
      check_eq("rst_period", int'(period), 0);
      check_eq("rst_word", int'(word_est), 0);
      check_eq("rst_pv", int'(period_valid), 0);
      check_eq("rst_wv", int'(word_valid), 0);
      check_eq("rst_nosig", int'(no_signal), 0);
      check_eq("rst_busy", int'(busy), 0);
      reset  = 1'b1;
      enable = 1'b1;

      measure("w1a", 256, 1);
      measure("w1b", 256, 1);

      wait_pv("gl_sync", 400, n);
      inject = 1'b1;
      wait_pv("gl_pv1", 400, n);
      check_eq("gl_gap1", n, 256);
      check_eq("gl_period1", int'(period), 256);
      wait_pv("gl_pv2", 400, n);
      check_eq("gl_gap2", n, 256);
      check_eq("gl_period2", int'(period), 256);
      inject = 1'b0;

      wait_pv("dis_sync", 400, n);
      repeat (3) @(negedge clk);
      check_eq("dis_busy_before", int'(busy), 1);
      enable = 1'b0;
      @(negedge clk);
      check_eq("dis_busy_after", int'(busy), 0);
      pulses = 0;
      repeat (300) begin
         @(negedge clk);
         if (period_valid || word_valid) pulses++;
      end
      check_eq("dis_pulses", pulses, 0);
      check_eq("dis_period", int'(period), 256);
      check_eq("dis_word", int'(word_est), 1);

      enable = 1'b1;
      wait_pv("rmd_sync", 1200, n);
      repeat (2) @(negedge clk);
      check_eq("rmd_busy_before", int'(busy), 1);
      reset = 1'b0;
      #1;
      check_eq("rmd_period", int'(period), 0);
      check_eq("rmd_word", int'(word_est), 0);
      check_eq("rmd_busy", int'(busy), 0);
      check_eq("rmd_pv", int'(period_valid), 0);
      check_eq("rmd_nosig", int'(no_signal), 0);
      repeat (200) @(negedge clk);
      reset = 1'b1;
      measure("rmd_w1", 256, 1);

      for (int k = 0; k < 3; k++) begin
         enable = 1'b0;
         repeat (2) @(negedge clk);
         step = 8'(steps[k]);
         @(negedge clk);
         enable = 1'b1;
         measure($sformatf("w%0da", steps[k]), periods[k], words[k]);
         measure($sformatf("w%0db", steps[k]), periods[k], words[k]);
         measure($sformatf("w%0dc", steps[k]), periods[k], words[k]);
      end

      wait_pv("st_sync", 100, n);
      stall = 1'b1;
      wait_wv("st_last_lat", n);
      pulses = 0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
         if (word_valid) pulses++;
      end while (!no_signal && n < 5000);
      check_eq("st_nosig", int'(no_signal), 1);
      check_eq("st_timeout_gap", n + 14, 4095);
      check_eq("st_word", int'(word_est), 0);
      check_eq("st_wv", pulses, 0);
      step  = 8'd2;
      stall = 1'b0;
      wait_pv("st_resume_pv", 1200, n);
      check_eq("st_resume_nosig", int'(no_signal), 0);
      check_eq("st_resume_period", int'(period), 128);
      wait_wv("st_resume_lat", n);
      check_eq("st_resume_word", int'(word_est), 2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
